// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: default widths and result-select codes.
package wb_stage_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    MD_F    = 2'b00,
    MD_MEM  = 2'b01,
    MD_SLT  = 2'b10,
    MD_RSVD = 2'b11
  } md_sel_e;

endpackage : wb_stage_pkg

// File: rtl/wb_result_mux.sv
// Combinational write-back result select: ALU result, memory data, SLT bit or zero.
module wb_result_mux
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic [1:0]        md,
  input  logic              vxorn,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result_c
);

  // Reserved code falls through to zero so BUS_D is always defined.
  always_comb begin
    result_c = '0;
    case (md)
      MD_F:    result_c = f;
      MD_MEM:  result_c = data;
      MD_SLT:  result_c = {{(DATA_W-1){1'b0}}, vxorn};
      default: result_c = '0;
    endcase
  end

endmodule : wb_result_mux

// File: rtl/wb_stage.sv
// Write-back stage: EX/WB pipeline register feeding the register-file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              RW,
  input  logic [ADDR_W-1:0] DA,
  input  logic [1:0]        MD,
  input  logic              VxorN,
  input  logic [DATA_W-1:0] F,
  input  logic [DATA_W-1:0] Data,
  output logic [DATA_W-1:0] BUS_D,
  output logic              RW_out,
  output logic [ADDR_W-1:0] DA_out
);

  logic              rw_q;
  logic [ADDR_W-1:0] da_q;
  logic [1:0]        md_q;
  logic              vxorn_q;
  logic [DATA_W-1:0] f_q;
  logic [DATA_W-1:0] data_q;

  // Unconditional capture every cycle; reset clears the in-flight fields.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rw_q    <= 1'b0;
      da_q    <= '0;
      md_q    <= 2'b00;
      vxorn_q <= 1'b0;
      f_q     <= '0;
      data_q  <= '0;
    end else begin
      rw_q    <= RW;
      da_q    <= DA;
      md_q    <= MD;
      vxorn_q <= VxorN;
      f_q     <= F;
      data_q  <= Data;
    end
  end

  wb_result_mux #(
    .DATA_W (DATA_W)
  ) u_result_mux (
    .md       (md_q),
    .vxorn    (vxorn_q),
    .f        (f_q),
    .data     (data_q),
    .result_c (BUS_D)
  );

  assign RW_out = rw_q;
  assign DA_out = da_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues expected outputs, monitor checks after each edge.
module tb_wb_stage;

  logic        CLOCK;
  logic        RESET;
  logic        RW;
  logic [4:0]  DA;
  logic [1:0]  MD;
  logic        VxorN;
  logic [31:0] F;
  logic [31:0] Data;
  logic [31:0] BUS_D;
  logic        RW_out;
  logic [4:0]  DA_out;

  typedef struct {
    logic [31:0] bus;
    logic        rw;
    logic [4:0]  da;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  wb_stage dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .RW     (RW),
    .DA     (DA),
    .MD     (MD),
    .VxorN  (VxorN),
    .F      (F),
    .Data   (Data),
    .BUS_D  (BUS_D),
    .RW_out (RW_out),
    .DA_out (DA_out)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Reference rule for the write-back value, written from the select-code table.
  function automatic exp_t model(input logic rw, input logic [4:0] da, input logic [1:0] md,
                                 input logic v, input logic [31:0] f, input logic [31:0] d);
    exp_t e;
    e.rw = rw;
    e.da = da;
    if (md == 2'd0)      e.bus = f;
    else if (md == 2'd1) e.bus = d;
    else if (md == 2'd2) e.bus = v ? 32'd1 : 32'd0;
    else                 e.bus = 32'd0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string name, input exp_t e);
    chk({name, ".bus_d"}, BUS_D, e.bus);
    chk({name, ".rw_out"}, {31'd0, RW_out}, {31'd0, e.rw});
    chk({name, ".da_out"}, {27'd0, DA_out}, {27'd0, e.da});
  endtask

  // Called at a falling edge: apply inputs, confirm outputs hold, queue the expected capture.
  task automatic step(input logic rw, input logic [4:0] da, input logic [1:0] md,
                      input logic v, input logic [31:0] f, input logic [31:0] d);
    exp_t e;
    RW = rw; DA = da; MD = md; VxorN = v; F = f; Data = d;
    #1;
    chk_outputs("hold", last);
    e = model(rw, da, md, v, f, d);
    q.push_back(e);
    last = e;
    @(negedge CLOCK);
  endtask

  // Called at a falling edge: async reset pulse between edges, inputs left unchanged.
  task automatic reset_pulse();
    exp_t z;
    z.bus = '0; z.rw = 1'b0; z.da = '0;
    RESET = 1'b0;
    #1;
    chk_outputs("midreset", z);
    RESET = 1'b1;
    q.push_back(last);
    @(negedge CLOCK);
  endtask

  // Monitor: one expected entry per capture edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_outputs("edge", e);
      end
    end
  end

  initial begin
    exp_t z;
    z.bus = '0; z.rw = 1'b0; z.da = '0;
    RESET = 1'b1;
    RW = 1'b1; DA = 5'h1F; MD = 2'b00; VxorN = 1'b1; F = 32'hFFFF_FFFF; Data = 32'hDDDD_DDDD;
    #1;
    RESET = 1'b0;
    #1;
    chk_outputs("reset_async", z);
    @(posedge CLOCK); @(posedge CLOCK);
    #1;
    chk_outputs("reset_held", z);
    @(negedge CLOCK);
    RESET = 1'b1;
    last = z;

    step(1'b1, 5'h0A, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'hDDDD_DDDD);
    step(1'b1, 5'h0A, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hDDDD_DDDD);
    reset_pulse();
    step(1'b0, 5'h03, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'hDDDD_DDDD);
    step(1'b1, 5'h00, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'hDDDD_DDDD);
    step(1'b1, 5'h1F, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hDDDD_DDDD);
    step(1'b0, 5'h11, 2'b00, 1'b0, 32'h1234_5678, 32'h8765_4321);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) reset_pulse();
      else step(1'($urandom), 5'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    end

    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the pipelined 32-bit RISC datapath. It sits after execute/memory and feeds the register file write port.
- It registers the EX/WB pipeline fields on CLOCK.
- It then selects the result value driven onto BUS_D (ALU result, memory data, or set-less-than bit) using MD.
- It forwards the register-file write enable and destination address alongside the selected value.

Parameters:
- DATA_W, 32, datapath width of F, Data, BUS_D.
- ADDR_W, 5, register address width of DA, DA_out.

Ports:
- CLOCK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset
- RW  input  1  register-file write enable from the previous stage
- DA  input  ADDR_W  destination register address
- MD  input  2  result-select code
- VxorN  input  1  overflow XOR negative flag (signed less-than result)
- F  input  DATA_W  ALU/function-unit result
- Data  input  DATA_W  memory read data
- BUS_D  output  DATA_W  selected write-back value to the register file
- RW_out  output  1  registered write enable
- DA_out  output  ADDR_W  registered destination address

Behaviour:
- Pipeline register: RW, DA, MD, VxorN, F and Data are each captured on every rising CLOCK edge. There is no enable or stall input.
- RESET low clears all pipeline registers to 0 asynchronously and immediately, regardless of CLOCK.
  - While RESET is low: BUS_D=0, RW_out=0, DA_out=0.
  - Release is synchronous to the next edge; the first capture occurs on the first rising edge with RESET high.
- Latency: an input set applied before edge N appears on the outputs right after edge N (one cycle).
- RW_out and DA_out are the registered RW and DA, unmodified. A write to address 0 is not suppressed; register-0 policy belongs to the register file.
- BUS_D is combinational from the registered fields and has no second register stage. MD select:
  - 00: F.
  - 01: Data.
  - 10: zero-extended VxorN, i.e. {(DATA_W-1) zeros, VxorN}, giving 0x00000001 or 0x00000000.
  - 11: reserved; drives all zeros.
- BUS_D is a pure mux; no arithmetic or sign-extension is performed on F or Data.
- Mid-operation reset: outputs go to 0 within the same cycle, and the in-flight value is discarded.
- Outputs never show X after reset, including when inputs were never driven before the first post-reset edge.

Decomposition:
- Shared package holds:
  - MD encodings: MD_F=2'b00, MD_MEM=2'b01, MD_SLT=2'b10, MD_RSVD=2'b11.
  - DATA_W and ADDR_W defaults.
- One natural sub-module: wb_result_mux.
  - Purely combinational 4:1 select of F / Data / zero-extended VxorN / zero, keyed by MD.
  - The top level holds the async-reset pipeline register and instantiates this mux.

Test Plan:
- Reset: hold RESET low with arbitrary inputs (F=0xFFFFFFFF, RW=1, DA=5'h1F) -> BUS_D=0, RW_out=0, DA_out=0 immediately, with no clock edge needed.
- ALU path: RESET high, F=0xFFFFFFFF, Data=0xDDDDDDDD, VxorN=1, MD=00, RW=1, DA=5'h0A -> after next rising edge BUS_D=0xFFFFFFFF, RW_out=1, DA_out=0x0A.
- Memory path: same F/Data/VxorN, MD=01 -> after next edge BUS_D=0xDDDDDDDD.
- Set-less-than path: MD=10, VxorN=1 -> BUS_D=0x00000001; then VxorN=0 -> BUS_D=0x00000000 one edge later.
- Reserved select and latency: MD=11 -> BUS_D=0x00000000. Changing any input between edges must not change outputs until the next rising edge.
- Reset mid-stream: with BUS_D=0xDDDDDDDD, pulse RESET low between edges -> all outputs 0 at once. After release, the first edge restores values from the current inputs.
